// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
// Element tables are indexed directly by state_t so IDLE/DRAIN entries are padding.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    M0    = 3'd1,
    M1    = 3'd2,
    M2    = 3'd3,
    M3    = 3'd4,
    M4    = 3'd5,
    M5    = 3'd6,
    DRAIN = 3'd7
  } state_t;

  // Bit n of each table describes the element run in state n.
  // DRAIN is marked "up" so the address counter parks at 0 after M5.
  localparam logic [7:0] ELEM_UP        = 8'b1100_1110;
  localparam logic [7:0] ELEM_HAS_READ  = 8'b0111_1100;
  localparam logic [7:0] ELEM_HAS_WRITE = 8'b0011_1110;
  localparam logic [7:0] ELEM_RD_BG     = 8'b0010_1000;
  localparam logic [7:0] ELEM_WR_BG     = 8'b0001_0100;

  function automatic state_t next_state(state_t s);
    state_t n;
    if (s == DRAIN) begin
      n = IDLE;
    end else begin
      n = state_t'(s + 3'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/sram_bist_ctrl_if.sv
// Dual-address SRAM port: BIST controller is the master, the SRAM the slave.
interface sram_bist_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);

  logic                     mem_wren;
  logic                     mem_rden;
  logic [$clog2(DEPTH)-1:0] mem_wr_addr;
  logic [$clog2(DEPTH)-1:0] mem_rd_addr;
  logic [WIDTH-1:0]         mem_wr_data;
  logic [WIDTH-1:0]         mem_rd_data;

  modport master (
    output mem_wren,
    output mem_rden,
    output mem_wr_addr,
    output mem_rd_addr,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_wren,
    input  mem_rden,
    input  mem_wr_addr,
    input  mem_rd_addr,
    input  mem_wr_data,
    output mem_rd_data
  );

endinterface

// File: rtl/sram_bist_cmp.sv
// One-cycle read-compare pipeline with a saturating miscompare counter and
// first-failure capture of address, expected word and read word.
module sram_bist_cmp #(
  parameter int WIDTH = 32,
  parameter int AW    = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             rd_issue,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_exp,
  input  logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [AW-1:0]    err_addr,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic             no_fail_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             chk_q, chk_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;
  logic [WIDTH-1:0] err_exp_q, err_exp_d;
  logic [WIDTH-1:0] err_got_q, err_got_d;
  logic             mismatch;

  // Expected word and address travel one cycle alongside the read so they
  // line up with the registered SRAM data.
  always_comb begin
    chk_d      = rd_issue;
    addr_d     = rd_addr;
    exp_d      = rd_exp;
    fail_cnt_d = fail_cnt_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    mismatch   = chk_q && (rd_data != exp_q);

    if (clear) begin
      chk_d      = 1'b0;
      fail_cnt_d = '0;
      err_addr_d = '0;
      err_exp_d  = '0;
      err_got_d  = '0;
    end else if (mismatch) begin
      if (fail_cnt_q != CNT_MAX) begin
        fail_cnt_d = fail_cnt_q + 1'b1;
      end
      if (fail_cnt_q == '0) begin
        err_addr_d = addr_q;
        err_exp_d  = exp_q;
        err_got_d  = rd_data;
      end
    end

    no_fail_next = (fail_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q      <= 1'b0;
      addr_q     <= '0;
      exp_q      <= '0;
      fail_cnt_q <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      exp_q      <= exp_d;
      fail_cnt_q <= fail_cnt_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  assign fail_cnt = fail_cnt_q;
  assign err_addr = err_addr_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;

endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller: element FSM and address counter driving the SRAM
// port, with read checking delegated to sram_bist_cmp.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [$clog2(DEPTH)-1:0] err_addr,
  output logic [WIDTH-1:0]         err_exp,
  output logic [WIDTH-1:0]         err_got,
  sram_bist_ctrl_if.master         mem
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            phase_q, phase_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            wren, rden, clear;
  logic [WIDTH-1:0] wr_data, rd_exp;
  logic            elem_up, has_read, has_write, at_end;
  state_t          nxt;
  logic            no_fail_next;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    clear     = 1'b0;
    wren      = 1'b0;
    rden      = 1'b0;
    wr_data   = '0;
    rd_exp    = '0;
    elem_up   = ELEM_UP[state_q];
    has_read  = ELEM_HAS_READ[state_q];
    has_write = ELEM_HAS_WRITE[state_q];
    nxt       = next_state(state_q);
    at_end    = elem_up ? (addr_q == LAST_ADDR) : (addr_q == '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = M0;
          addr_d  = '0;
          phase_d = 1'b0;
          pass_d  = 1'b0;
          clear   = 1'b1;
        end
      end

      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = no_fail_next;
      end

      default: begin
        // Read-then-write elements read in phase 0 and write the same
        // address in phase 1, so wren and rden never overlap.
        if (has_read && (!has_write || !phase_q)) begin
          rden   = 1'b1;
          rd_exp = {WIDTH{ELEM_RD_BG[state_q]}};
        end else begin
          wren    = 1'b1;
          wr_data = {WIDTH{ELEM_WR_BG[state_q]}};
        end

        if (has_read && has_write && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (at_end) begin
            state_d = nxt;
            addr_d  = ELEM_UP[nxt] ? '0 : LAST_ADDR;
          end else if (elem_up) begin
            addr_d = addr_q + 1'b1;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  sram_bist_cmp #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .rd_issue     (rden),
    .rd_addr      (addr_q),
    .rd_exp       (rd_exp),
    .rd_data      (mem.mem_rd_data),
    .fail_cnt     (fail_cnt),
    .err_addr     (err_addr),
    .err_exp      (err_exp),
    .err_got      (err_got),
    .no_fail_next (no_fail_next)
  );

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign pass            = pass_q;
  assign mem.mem_wren    = wren;
  assign mem.mem_rden    = rden;
  assign mem.mem_wr_addr = addr_q;
  assign mem.mem_rd_addr = addr_q;
  assign mem.mem_wr_data = wr_data;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: table of whole-run vectors against a
// behavioural SRAM, plus hand sequences for ordering, reset abort and saturation.
module tb_sram_bist_ctrl;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_s;
  logic busy, done, pass;
  logic [15:0]   fail_cnt;
  logic [AW-1:0] err_addr;
  logic [W-1:0]  err_exp, err_got;
  logic busy_s, done_s, pass_s;
  logic [1:0]    fail_cnt_s;
  logic [AW-1:0] err_addr_s;
  logic [W-1:0]  err_exp_s, err_got_s;

  sram_bist_ctrl_if #(.WIDTH(W), .DEPTH(D)) mem_if ();
  sram_bist_ctrl_if #(.WIDTH(W), .DEPTH(D)) mem_if_s ();

  sram_bist_ctrl #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .mem(mem_if)
  );

  sram_bist_ctrl #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_cnt(fail_cnt_s), .err_addr(err_addr_s), .err_exp(err_exp_s), .err_got(err_got_s),
    .mem(mem_if_s)
  );

  // Behavioural SRAMs with one-cycle registered read; optional stuck bit 3 at address 5.
  logic          stuck_en;
  logic [W-1:0]  mem_a [D];
  logic [W-1:0]  rdq_a;
  logic [AW-1:0] rda_a;
  logic [W-1:0]  mem_b [D];
  logic [W-1:0]  rdq_b;

  always @(posedge clk) begin
    if (rst) begin
      rdq_a <= '0;
      rda_a <= '0;
      rdq_b <= '0;
    end else begin
      if (mem_if.mem_wren) mem_a[mem_if.mem_wr_addr] <= mem_if.mem_wr_data;
      if (mem_if.mem_rden) begin
        rdq_a <= mem_a[mem_if.mem_rd_addr];
        rda_a <= mem_if.mem_rd_addr;
      end
      if (mem_if_s.mem_wren) mem_b[mem_if_s.mem_wr_addr] <= mem_if_s.mem_wr_data;
      if (mem_if_s.mem_rden) rdq_b <= mem_b[mem_if_s.mem_rd_addr];
    end
  end

  assign mem_if.mem_rd_data   = rdq_a | ((stuck_en && rda_a == 4'd5) ? 8'h08 : 8'h00);
  assign mem_if_s.mem_rd_data = ~rdq_b;

  int done_count = 0;
  int collision_count = 0;
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (mem_if.mem_wren === 1'b1 && mem_if.mem_rden === 1'b1) collision_count++;
  end

  int total = 0;
  int bad = 0;

  logic          trace_rden [200];
  logic          trace_wren [200];
  logic [AW-1:0] trace_rd_addr [200];
  logic [AW-1:0] trace_wr_addr [200];

  typedef struct {
    bit           stuck;
    bit           repulse;
    bit           exp_pass;
    int           exp_fail;
    logic [AW-1:0] exp_addr;
    logic [W-1:0] exp_exp;
    logic [W-1:0] exp_got;
    int           exp_len;
  } vec_t;

  vec_t vecs [4];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One full run on the main DUT, tracing memory commands per busy cycle.
  task automatic applyStimulus(input bit repulse, output int busy_len, output bit done_at_end);
    busy_len = 0;
    done_at_end = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (busy === 1'b1 && busy_len < 400) begin
      if (busy_len < 200) begin
        trace_rden[busy_len]    = mem_if.mem_rden;
        trace_wren[busy_len]    = mem_if.mem_wren;
        trace_rd_addr[busy_len] = mem_if.mem_rd_addr;
        trace_wr_addr[busy_len] = mem_if.mem_wr_addr;
      end
      start = repulse && (busy_len == 10 || busy_len == 100);
      busy_len++;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy_len >= 400) checkOutput("run_timeout", 32'(busy_len), 32'd161);
    done_at_end = done;
  endtask

  initial begin
    int len;
    bit dae;
    int d0;
    int c0;
    int k;

    vecs[0] = '{stuck: 0, repulse: 0, exp_pass: 1, exp_fail: 0, exp_addr: 4'd0, exp_exp: 8'h00, exp_got: 8'h00, exp_len: 161};
    // Stuck bit 3 at address 5 trips every r0 read there: M1, M3 and M5.
    vecs[1] = '{stuck: 1, repulse: 0, exp_pass: 0, exp_fail: 3, exp_addr: 4'd5, exp_exp: 8'h00, exp_got: 8'h08, exp_len: 161};
    vecs[2] = '{stuck: 0, repulse: 0, exp_pass: 1, exp_fail: 0, exp_addr: 4'd0, exp_exp: 8'h00, exp_got: 8'h00, exp_len: 161};
    vecs[3] = '{stuck: 0, repulse: 1, exp_pass: 1, exp_fail: 0, exp_addr: 4'd0, exp_exp: 8'h00, exp_got: 8'h00, exp_len: 161};

    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    stuck_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_pass", pass, 1'b0);
    checkOutput("rst_fail_cnt", fail_cnt, 16'd0);
    checkOutput("rst_wren", mem_if.mem_wren, 1'b0);
    checkOutput("rst_rden", mem_if.mem_rden, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      stuck_en = vecs[i].stuck;
      d0 = done_count;
      c0 = collision_count;
      applyStimulus(vecs[i].repulse, len, dae);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("v%0d_busy_len", i), 32'(len), 32'(vecs[i].exp_len));
      checkOutput($sformatf("v%0d_done_at_end", i), dae, 1'b1);
      checkOutput($sformatf("v%0d_done_pulses", i), 32'(done_count - d0), 32'd1);
      checkOutput($sformatf("v%0d_collisions", i), 32'(collision_count - c0), 32'd0);
      checkOutput($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      checkOutput($sformatf("v%0d_fail_cnt", i), fail_cnt, 32'(vecs[i].exp_fail));
      checkOutput($sformatf("v%0d_err_addr", i), err_addr, vecs[i].exp_addr);
      checkOutput($sformatf("v%0d_err_exp", i), err_exp, vecs[i].exp_exp);
      checkOutput($sformatf("v%0d_err_got", i), err_got, vecs[i].exp_got);
    end
    stuck_en = 1'b0;

    // M3 starts at busy cycle 80 and walks down; M5 starts at 144 and walks up.
    for (int j = 0; j < 16; j++) begin
      checkOutput($sformatf("m3_rd_%0d", j), {trace_rden[80 + 2*j], trace_wren[80 + 2*j], trace_rd_addr[80 + 2*j]},
                  {1'b1, 1'b0, 4'(15 - j)});
      checkOutput($sformatf("m3_wr_%0d", j), {trace_rden[81 + 2*j], trace_wren[81 + 2*j], trace_wr_addr[81 + 2*j]},
                  {1'b0, 1'b1, 4'(15 - j)});
      checkOutput($sformatf("m5_rd_%0d", j), {trace_rden[144 + j], trace_wren[144 + j], trace_rd_addr[144 + j]},
                  {1'b1, 1'b0, 4'(j)});
    end
    checkOutput("drain_no_op", {trace_rden[160], trace_wren[160]}, 2'b00);

    // Reset in the middle of a run aborts without a done pulse.
    d0 = done_count;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      k++;
      @(negedge clk);
    end
    checkOutput("abort_reached_40", 32'(k), 32'd40);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_wren", mem_if.mem_wren, 1'b0);
    checkOutput("abort_rden", mem_if.mem_rden, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("abort_pass", pass, 1'b0);
    applyStimulus(1'b0, len, dae);
    @(negedge clk);
    checkOutput("rerun_len", 32'(len), 32'd161);
    checkOutput("rerun_pass", pass, 1'b1);

    // Every read inverted: the 2-bit counter saturates and the first capture is address 0 of M1.
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    k = 0;
    while (busy_s === 1'b1 && k < 400) begin
      k++;
      @(negedge clk);
    end
    checkOutput("sat_len", 32'(k), 32'd161);
    checkOutput("sat_done", done_s, 1'b1);
    @(negedge clk);
    checkOutput("sat_fail_cnt", fail_cnt_s, 2'd3);
    checkOutput("sat_err_addr", err_addr_s, 4'd0);
    checkOutput("sat_err_exp", err_exp_s, 8'h00);
    checkOutput("sat_err_got", err_got_s, 8'hFF);
    checkOutput("sat_pass", pass_s, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
